// File: rtl/seq_alu.sv
// Sequential unsigned ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete on accept; MUL/DIV/MOD iterate one bit per cycle.
module seq_alu #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   select,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] result,
  output logic [1:0]   flags,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned SW = $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [3:0] {
    OP_MOV = 4'd0, OP_CMP = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
    OP_MUL = 4'd4, OP_DIV = 4'd5, OP_XOR = 4'd6, OP_AND = 4'd7,
    OP_NOT = 4'd8, OP_SHL = 4'd9, OP_SHR = 4'd10, OP_MOD = 4'd11
  } op_e;

  state_e         state;
  op_e            op_q;
  logic [N-1:0]   op_a, op_b, hi, lo;
  logic [SW-1:0]  cnt;

  op_e            sel_op;
  logic           accept, is_iter;
  logic [N-1:0]   s_res;
  logic           s_c, s_z;
  logic [N:0]     add_full, sub_full, shl_full, shr_full;
  logic [SW-1:0]  sh;

  logic [N:0]     mul_sum, div_sh;
  logic [N-1:0]   div_diff, hi_nx, lo_nx, it_res;
  logic           div_ge, it_c;

  assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign sel_op   = op_e'(select);
  assign is_iter  = (sel_op == OP_MUL) || (sel_op == OP_DIV) || (sel_op == OP_MOD);

  always_comb begin
    sh       = b[SW-1:0];
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} - {1'b0, b};
    // Bit N of the widened left shift is a[N-s]; bit 0 of the right shift is a[s-1].
    shl_full = {1'b0, a} << sh;
    shr_full = {a, 1'b0} >> sh;
    s_res    = '0;
    s_c      = 1'b0;
    case (sel_op)
      OP_MOV: s_res = b;
      OP_CMP: begin s_res = a; s_c = (a < b); end
      OP_ADD: begin s_res = add_full[N-1:0]; s_c = add_full[N]; end
      OP_SUB: begin s_res = sub_full[N-1:0]; s_c = sub_full[N]; end
      OP_XOR: s_res = a ^ b;
      OP_AND: s_res = a & b;
      OP_NOT: s_res = ~a;
      OP_SHL: begin s_res = shl_full[N-1:0]; s_c = shl_full[N]; end
      OP_SHR: begin s_res = shr_full[N:1]; s_c = shr_full[0]; end
      default: begin s_res = '0; s_c = 1'b0; end
    endcase
    s_z = (sel_op == OP_CMP) ? (a == b) : (s_res == '0);
  end

  // hi/lo form {product} for MUL and {remainder, quotient} for DIV/MOD.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, op_b} : '0);
    div_sh   = {hi, lo[N-1]};
    div_ge   = (div_sh >= {1'b0, op_b});
    div_diff = div_sh[N-1:0] - op_b;
    if (op_q == OP_MUL) begin
      hi_nx = mul_sum[N:1];
      lo_nx = {mul_sum[0], lo[N-1:1]};
    end else begin
      hi_nx = div_ge ? div_diff : div_sh[N-1:0];
      lo_nx = {lo[N-2:0], div_ge};
    end
    it_res = '0;
    it_c   = 1'b0;
    case (op_q)
      OP_MUL: begin it_res = lo_nx; it_c = (hi_nx != '0); end
      OP_DIV: begin
        it_res = (op_b == '0) ? '1 : lo_nx;
        it_c   = (op_b == '0);
      end
      OP_MOD: begin
        it_res = (op_b == '0) ? op_a : hi_nx;
        it_c   = (op_b == '0);
      end
      default: begin it_res = '0; it_c = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_MOV;
      op_a      <= '0;
      op_b      <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_iter) begin
              state     <= BUSY;
              out_valid <= 1'b0;
              op_q      <= sel_op;
              op_a      <= a;
              op_b      <= b;
              hi        <= '0;
              lo        <= a;
              cnt       <= '0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= s_res;
              flags     <= {s_c, s_z};
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == SW'(N - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= it_res;
            flags     <= {it_c, (it_res == '0)};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
